spi_reg_master: RTL and testbench
=================================

Name: spi_reg_master

Overview:
SPI mode-0 initiator for the team's 8-bit SPI register-slave protocol. It lets on-chip logic (test sequencer, chained tile, FPGA-side harness) write and read the slave register map, for example P/E/M/Const, start, EOC poll and C readback on the RSA tile. A simple valid/ready request port drives it, and a one-cycle pulse returns the response. The block generates nss/sclk/mosi and samples miso.

Parameters:
ADDR_W, 3, register address width; legal range 1..7, zero-extended into the 7-bit command address field
REG_W, 8, register data width in bits (data phase length)
CLK_DIV, 4, clk cycles per sclk half-period; legal range >= 2 (>= 3 when MISO_SYNC_EN is set)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block idle and able to accept a request
req_write  in  1  1 = register write, 0 = register read
req_addr  in  ADDR_W  register address
req_wdata  in  REG_W  write data (ignored on reads)
rsp_valid  out  1  one-cycle pulse when a frame completes
rsp_rdata  out  REG_W  data shifted in during the data phase (valid with rsp_valid, held afterwards)
rsp_status  out  8  slave status byte shifted in during the command phase (held)
busy  out  1  high from request accept until the end of GAP
nss  out  1  chip select, active low
sclk  out  1  serial clock, idle low
mosi  out  1  master out
miso  in  1  master in

Behaviour:
- Reset values: nss=1, sclk=0, mosi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_status=0, state IDLE.
- Frame format, MSB first: command byte {write, addr[6:0]} followed by REG_W data bits.
  - mosi carries req_wdata on writes and zeros on reads.
  - The slave returns status during the command byte and register data during the data phase.
  - The master shifts in all 8+REG_W bits on every frame, including writes.
- Mode 0 timing:
  - mosi changes only while sclk is low: the first bit is driven at SETUP entry, later bits on each sclk falling edge.
  - miso is sampled on each internal sclk rising edge.
- Handshake: a request is accepted when req_valid && req_ready, and is captured in that cycle. req_ready drops the next cycle and stays low until the cycle after GAP ends.
- FSM states and durations:
  - IDLE: waits for an accepted request.
  - SETUP: nss=0, sclk=0, MSB on mosi; lasts CLK_DIV cycles.
  - SHIFT: (8+REG_W) sclk periods, each CLK_DIV cycles high then CLK_DIV cycles low. sclk ends low.
  - HOLD: nss=0, sclk=0 for CLK_DIV cycles.
  - GAP: nss=1 for CLK_DIV cycles, then return to IDLE.
- Latency: rsp_valid pulses on the first cycle of GAP, which is also the first cycle nss=1. With CLK_DIV=4, REG_W=8 this is 4*(1+32+1)=136 cycles after the accept cycle. Next accept is possible 4 cycles later.
- A half-period counter of width clog2(CLK_DIV) and a bit counter of width clog2(8+REG_W+1) wrap only at the state transitions above.
- Inputs: req_* are ignored while busy. A req_valid that arrives during a frame is held by the requester, not queued.
- Reset mid-frame: outputs go to their reset values immediately (nss rises asynchronously). No rsp_valid is produced for the aborted frame.
- sclk, nss and mosi are driven directly from flops (glitch-free).

Optional Feature:
MISO_SYNC_EN
- Defined: miso passes through a 2-flop synchronizer before sampling; sample timing is unchanged. This relies on CLK_DIV >= 3, because slave data changes a full half-period before the rising edge.
- Undefined: miso is sampled directly at the internal rising edge. This is for a synchronous, same-clock slave.

Decomposition:
- Shared package: command-byte bit positions (write bit 7, address 6:0), state encodings (IDLE/SETUP/SHIFT/HOLD/GAP), command byte width 8.
- One natural sub-module, spi_clk_gen: the half-period counter producing sclk, rise-tick and fall-tick strobes.
- The shift register and FSM stay in the top module.

Test Plan:
- Write addr 2, data 0xB5, CLK_DIV=4: checks the frame wire format.
  - nss low for 136 cycles.
  - mosi samples at sclk rises are 0x82 then 0xB5.
  - 16 sclk rises.
  - rsp_valid pulses once at nss rise.
- Read addr 6 against a slave model returning status 0x01 and data 0x3C:
  - mosi = 0x06, 0x00.
  - rsp_status = 0x01 and rsp_rdata = 0x3C with rsp_valid.
- Back-to-back with req_valid held high for writes to addr 3 then 4:
  - req_ready low throughout frame 1.
  - nss high for at least 4 cycles between the frames.
  - The second frame carries the correct address.
- rst_n low at bit 9 of SHIFT:
  - nss=1, sclk=0 within the same cycle.
  - No rsp_valid.
  - The next request runs a complete, correct frame.
- Loopback with miso tied to mosi, write 0xA5 to addr 5: rsp_status = 0x85, rsp_rdata = 0xA5, in both MISO_SYNC_EN builds.
- CLK_DIV=2 with the macro undefined, read addr 1 returning 0xFF: every sclk half-period is 2 cycles and rsp_rdata = 0xFF.

Source files
------------

// File: rtl/spi_reg_master_pkg.sv
// spi_reg_master_pkg: command-byte layout and FSM state encoding shared by the SPI register master
package spi_reg_master_pkg;
  localparam int CMD_W = 8;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_W = CMD_ADDR_MSB + 1;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_e;
endpackage

// File: rtl/spi_reg_master_clk_gen.sv
// spi_clk_gen: half-period counter driving sclk; rise/fall strobes fire in the cycle before the sclk edge
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic tgl_i,
  output logic end_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sclk_q, sclk_d;
  always_comb begin
    end_o = run_i && (cnt_q == CW'(CLK_DIV - 1));
    rise_o = end_o && tgl_i && !sclk_q;
    fall_o = end_o && tgl_i && sclk_q;
    cnt_d = (!run_i || end_o) ? '0 : cnt_q + CW'(1);
    sclk_d = sclk_q ^ (end_o && tgl_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
  assign sclk_o = sclk_q;
endmodule

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 initiator for the 8-bit register-slave protocol (status + data shifted back every frame).
// Define MISO_SYNC_EN to pass miso through a 2-flop synchronizer for a slave on another clock.
module spi_reg_master import spi_reg_master_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int REG_W = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic [7:0]        rsp_status,
  output logic              busy,
  output logic              nss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);
  localparam int N = CMD_W + REG_W;
  localparam int BW = $clog2(N + 1);
  state_e state_q, state_d;
  logic [N-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [REG_W-1:0] rdata_q, rdata_d;
  logic [7:0] status_q, status_d;
  logic nss_q, nss_d, mosi_q, mosi_d, vld_q, vld_d;
  logic tick, rise, fall, tgl, last, miso_s;
  logic [CMD_W-1:0] cmd;
`ifdef MISO_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], miso};
  end
  assign miso_s = sync_q[1];
`else
  assign miso_s = miso;
`endif
  assign last = bit_q == BW'(N);
  // sclk keeps toggling in SHIFT until the final low half-period after the last rise
  assign tgl = (state_q == ST_SETUP) || (state_q == ST_SHIFT && (sclk || !last));
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk), .rst_n(rst_n), .run_i(state_q != ST_IDLE), .tgl_i(tgl),
    .end_o(tick), .rise_o(rise), .fall_o(fall), .sclk_o(sclk)
  );
  always_comb begin
    cmd = '0;
    cmd[CMD_WR_BIT] = req_write;
    cmd[CMD_ADDR_MSB:0] = CMD_ADDR_W'(req_addr);
  end
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    bit_d = bit_q;
    nss_d = nss_q;
    mosi_d = mosi_q;
    vld_d = 1'b0;
    rdata_d = rdata_q;
    status_d = status_q;
    if (rise) begin
      rx_d = {rx_q[N-2:0], miso_s};
      bit_d = bit_q + BW'(1);
    end
    if (fall) begin
      tx_d = tx_q << 1;
      mosi_d = tx_q[N-2];
    end
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_SETUP;
        tx_d = {cmd, req_wdata & {REG_W{req_write}}};
        mosi_d = cmd[CMD_W-1];
        nss_d = 1'b0;
        bit_d = '0;
      end
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && !sclk && last) state_d = ST_HOLD;
      ST_HOLD: if (tick) begin
        state_d = ST_GAP;
        nss_d = 1'b1;
        vld_d = 1'b1;
        status_d = rx_q[N-1 -: CMD_W];
        rdata_d = rx_q[REG_W-1:0];
      end
      ST_GAP: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q <= '0;
      rx_q <= '0;
      bit_q <= '0;
      nss_q <= 1'b1;
      mosi_q <= 1'b0;
      vld_q <= 1'b0;
      rdata_q <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      nss_q <= nss_d;
      mosi_q <= mosi_d;
      vld_q <= vld_d;
      rdata_q <= rdata_d;
      status_q <= status_d;
    end
  end
  assign req_ready = state_q == ST_IDLE;
  assign busy = !req_ready;
  assign nss = nss_q;
  assign mosi = mosi_q;
  assign rsp_valid = vld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_status = status_q;
endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: directed frames against a mode-0 slave model, loopback and a CLK_DIV=2 instance
module tb_spi_reg_master;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, rsp_valid, busy, nss, sclk, mosi, miso;
  logic [7:0] rsp_rdata, rsp_status;
  logic req_valid2 = 1'b0, req_write2 = 1'b0;
  logic [2:0] req_addr2 = '0;
  logic [7:0] req_wdata2 = '0;
  logic req_ready2, rsp_valid2, busy2, nss2, sclk2, mosi2;
  logic [7:0] rsp_rdata2, rsp_status2;
  logic loop = 1'b0;
  logic [15:0] slave_frame = '0;
  logic [4:0] kf = '0;
  logic miso_s;
  spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .busy(busy), .nss(nss), .sclk(sclk), .mosi(mosi), .miso(miso)
  );
  spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .rsp_status(rsp_status2), .busy(busy2), .nss(nss2), .sclk(sclk2), .mosi(mosi2), .miso(1'b1)
  );
  // slave: bit kf of slave_frame (MSB first) is presented from nss fall and advanced on each sclk fall
  always @(negedge sclk or posedge nss) kf <= nss ? 5'd0 : kf + 5'd1;
  assign miso_s = kf[4] ? 1'b0 : slave_frame[~kf[3:0]];
  assign miso = loop ? mosi : miso_s;
  int cyc = 0, rises = 0, nss_low = 0, rsp_cnt = 0, rdy_bad = 0, hi_run = 0, last_gap = 0;
  int rises2 = 0, hp_bad = 0, lr2 = -1, nf2 = 0;
  logic [15:0] mosi_cap = '0;
  logic [7:0] st_cap = '0, rd_cap = '0;
  logic rsp_edge = 1'b0, sclk_p = 1'b0, nss_p = 1'b1, s2p = 1'b0, nss2p = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (sclk && !sclk_p) begin
      rises++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    if (!nss) nss_low++;
    if (!nss && req_ready) rdy_bad++;
    if (nss) hi_run++;
    else begin
      if (nss_p) last_gap = hi_run;
      hi_run = 0;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_edge = nss && !nss_p;
      st_cap = rsp_status;
      rd_cap = rsp_rdata;
    end
    if (!nss2 && nss2p) nf2 = cyc;
    if (sclk2 && !s2p) begin
      if (lr2 >= 0 ? (cyc - lr2 != 4) : (cyc - nf2 != 2)) hp_bad++;
      lr2 = cyc;
      rises2++;
    end
    if (!sclk2 && s2p && cyc - lr2 != 2) hp_bad++;
    if (nss2) lr2 = -1;
    sclk_p = sclk;
    nss_p = nss;
    s2p = sclk2;
    nss2p = nss2;
  end
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_ready(input logic lvl);
    int n = 0;
    while (req_ready !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", n < 400, 1);
  endtask
  task automatic send(input logic sel, input logic w, input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if (sel) {req_valid2, req_write2, req_addr2, req_wdata2} = {1'b1, w, a, d};
    else {req_valid, req_write, req_addr, req_wdata} = {1'b1, w, a, d};
    while (!(sel ? req_ready2 : req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 400, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_valid2 = 1'b0;
  endtask
  task automatic wait_rsp(input logic sel);
    int n = 0;
    while (!(sel ? rsp_valid2 : rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", n < 400, 1);
    @(negedge clk);
  endtask
  int r0, l0, c0, b0;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_nss", nss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_status", rsp_status, 0);
    rst_n = 1'b1;
    // write addr 2, 0xB5: wire format and frame length
    r0 = rises; l0 = nss_low; c0 = rsp_cnt;
    send(0, 1'b1, 3'd2, 8'hB5);
    wait_rsp(0);
    check("t1_nss_low", nss_low - l0, 136);
    check("t1_mosi", mosi_cap, 16'h82B5);
    check("t1_rises", rises - r0, 16);
    check("t1_rsp_cnt", rsp_cnt - c0, 1);
    check("t1_rsp_at_nss_rise", rsp_edge, 1);
    check("t1_pulse_len", rsp_valid, 0);
    // read addr 6, slave returns status 0x01 data 0x3C; wdata must not reach mosi
    slave_frame = 16'h013C;
    send(0, 1'b0, 3'd6, 8'hFF);
    wait_rsp(0);
    check("t2_mosi", mosi_cap, 16'h0600);
    check("t2_status_cap", st_cap, 8'h01);
    check("t2_rdata_cap", rd_cap, 8'h3C);
    repeat (10) @(negedge clk);
    check("t2_status_held", rsp_status, 8'h01);
    check("t2_rdata_held", rsp_rdata, 8'h3C);
    // back-to-back with req_valid held; changing req_* mid-frame must not disturb frame 1
    wait_ready(1);
    b0 = rdy_bad; c0 = rsp_cnt;
    @(negedge clk);
    {req_valid, req_write, req_addr, req_wdata} = {1'b1, 1'b1, 3'd3, 8'h11};
    wait_ready(0);
    check("t3_busy", busy, 1);
    req_addr = 3'd4;
    req_wdata = 8'h22;
    wait_rsp(0);
    check("t3_f1_mosi", mosi_cap, 16'h8311);
    wait_ready(1);
    wait_ready(0);
    req_valid = 1'b0;
    wait_rsp(0);
    check("t3_f2_mosi", mosi_cap, 16'h8422);
    check("t3_ready_low_in_frame", rdy_bad - b0, 0);
    check("t3_gap_ge4", last_gap >= 4, 1);
    check("t3_rsp_cnt", rsp_cnt - c0, 2);
    // reset at bit 9 of SHIFT
    slave_frame = 16'hFFFF;
    wait_ready(1);
    r0 = rises; c0 = rsp_cnt;
    send(0, 1'b1, 3'd7, 8'h5A);
    for (int i = 0; i < 400 && rises - r0 < 9; i++) @(negedge clk);
    check("t4_bit9", rises - r0, 9);
    #2 rst_n = 1'b0;
    #1;
    check("t4_nss", nss, 1);
    check("t4_sclk", sclk, 0);
    check("t4_ready", req_ready, 1);
    check("t4_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_no_rsp", rsp_cnt - c0, 0);
    check("t4_nss_idle", nss, 1);
    slave_frame = 16'h02C3;
    l0 = nss_low;
    send(0, 1'b0, 3'd1, 8'h00);
    wait_rsp(0);
    check("t4_mosi", mosi_cap, 16'h0100);
    check("t4_status", st_cap, 8'h02);
    check("t4_rdata", rd_cap, 8'hC3);
    check("t4_nss_low", nss_low - l0, 136);
    // loopback: miso follows mosi
    loop = 1'b1;
    send(0, 1'b1, 3'd5, 8'hA5);
    wait_rsp(0);
    check("t5_status", st_cap, 8'h85);
    check("t5_rdata", rd_cap, 8'hA5);
    loop = 1'b0;
    // CLK_DIV=2 instance, miso tied high
    r0 = rises2;
    send(1, 1'b0, 3'd1, 8'h00);
    wait_rsp(1);
    check("t6_rdata", rsp_rdata2, 8'hFF);
    check("t6_status", rsp_status2, 8'hFF);
    check("t6_rises", rises2 - r0, 16);
    check("t6_half_period", hp_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
